// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_pipe_if.sv
// Operation/result handshake bundle for shift_pipe; slave is the shifter's view.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import shift_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operand;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  shift_op_t          ctrl_shift_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, data_operand, ctrl_shiftamt, ctrl_shift_op, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  in_valid, data_operand, ctrl_shiftamt, ctrl_shift_op, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );

endinterface

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by DIST, then a register; 1-cycle latency.
// Holds its contents while downstream is not ready; ready = !valid || downstream ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = 5,
  parameter int DIST    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  shift_op_t          up_op,
  input  logic               up_sign,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [WIDTH-1:0]   dn_data,
  output logic [SHAMT_W-1:0] dn_shamt,
  output shift_op_t          dn_op,
  output logic               dn_sign,
  output logic [TAG_W-1:0]   dn_tag
);

  localparam int               SEL     = $clog2(DIST);
  localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> DIST);

  logic [WIDTH-1:0] shifted;

  // Arithmetic fill uses the operand's original sign bit carried down the pipe.
  always_comb begin
    shifted = up_data;
    if (up_shamt[SEL]) begin
      case (up_op)
        SHIFT_SLL: shifted = up_data << DIST;
        SHIFT_SRL: shifted = up_data >> DIST;
        SHIFT_SRA: shifted = (up_data >> DIST) | (HI_MASK & {WIDTH{up_sign}});
        SHIFT_ROL: shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
        default:   shifted = up_data;
      endcase
    end
  end

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_op    <= SHIFT_SLL;
      dn_sign  <= 1'b0;
      dn_tag   <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= shifted;
        dn_shamt <= up_shamt;
        dn_op    <= up_op;
        dn_sign  <= up_sign;
        dn_tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with tag; latency $clog2(WIDTH) cycles, 1 op/cycle.
// Combinational ready chain collapses bubbles; a stalled output holds result and tag stable.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic         clock,
  input logic         reset_n,
  shift_pipe_if.slave io
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Index 0 is the input side; index i+1 is the register of stage i.
  logic               vld  [SHAMT_W+1];
  logic               rdy  [SHAMT_W+1];
  logic [WIDTH-1:0]   dat  [SHAMT_W+1];
  logic [SHAMT_W-1:0] amt  [SHAMT_W+1];
  shift_op_t          op   [SHAMT_W+1];
  logic               sgn  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag  [SHAMT_W+1];

  assign vld[0] = io.in_valid;
  assign dat[0] = io.data_operand;
  assign amt[0] = io.ctrl_shiftamt;
  assign op[0]  = io.ctrl_shift_op;
  assign sgn[0] = io.data_operand[WIDTH-1];
  assign tag[0] = io.in_tag;

  assign rdy[SHAMT_W] = io.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      shift_stage #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .SHAMT_W (SHAMT_W),
        .DIST    (1 << gi)
      ) u_stage (
        .clock    (clock),
        .reset_n  (reset_n),
        .up_valid (vld[gi]),
        .up_ready (rdy[gi]),
        .up_data  (dat[gi]),
        .up_shamt (amt[gi]),
        .up_op    (op[gi]),
        .up_sign  (sgn[gi]),
        .up_tag   (tag[gi]),
        .dn_valid (vld[gi+1]),
        .dn_ready (rdy[gi+1]),
        .dn_data  (dat[gi+1]),
        .dn_shamt (amt[gi+1]),
        .dn_op    (op[gi+1]),
        .dn_sign  (sgn[gi+1]),
        .dn_tag   (tag[gi+1])
      );
    end
  endgenerate

  assign io.in_ready  = reset_n && rdy[0];
  assign io.out_valid = vld[SHAMT_W];
  assign io.result    = dat[SHAMT_W];
  assign io.out_tag   = tag[SHAMT_W];

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: expectations queued at input transfer, checked at output transfer.
module tb_shift_pipe;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          issue;
    bit          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  shift_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();

  shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  logic [31:0] exp_res = '0;
  bit          exp_lat = 1'b0;
  bit          rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] model(shift_op_t o, logic [31:0] d, logic [4:0] s);
    case (o)
      SHIFT_SLL: return d << s;
      SHIFT_SRL: return d >> s;
      SHIFT_SRA: return $unsigned($signed(d) >>> s);
      default:   return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input shift_op_t o, input logic [31:0] d, input logic [4:0] s,
                      input logic [4:0] t, input logic [31:0] e, input bit lat);
    bit ok = 1'b0;
    bus.in_valid      = 1'b1;
    bus.data_operand  = d;
    bus.ctrl_shiftamt = s;
    bus.ctrl_shift_op = o;
    bus.in_tag        = t;
    exp_res           = e;
    exp_lat           = lat;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check("drain_empty", 64'(sb.size()), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] r0;
    logic [4:0]  t0;

    bus.in_valid      = 1'b0;
    bus.data_operand  = '0;
    bus.ctrl_shiftamt = '0;
    bus.ctrl_shift_op = SHIFT_SLL;
    bus.in_tag        = '0;
    bus.out_ready     = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clock);
        cyc++;
        if (reset_n) begin
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              check("spurious_out", 1, 0);
            end else begin
              e = sb.pop_front();
              check("result", bus.result, e.res);
              check("out_tag", bus.out_tag, e.tag);
              if (e.lat) check("latency", 64'(cyc - e.issue), 5);
            end
          end
          if (bus.in_valid && bus.in_ready) begin
            e.res   = exp_res;
            e.tag   = bus.in_tag;
            e.issue = cyc;
            e.lat   = exp_lat;
            sb.push_back(e);
          end
        end
      end
    join_none

    // Reset state
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    #1 check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;

    // Directed operations with exact latency
    send(SHIFT_SLL, 32'h0000_00FF, 5'd8, 5'd3, 32'h0000_FF00, 1'b1);
    drain();
    send(SHIFT_SRA, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000, 1'b1);
    send(SHIFT_SRL, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000, 1'b1);
    drain();
    send(SHIFT_ROL, 32'h8000_0001, 5'd1,  5'd4, 32'h0000_0003, 1'b1);
    send(SHIFT_ROL, 32'h1234_5678, 5'd0,  5'd5, 32'h1234_5678, 1'b1);
    send(SHIFT_SLL, 32'hFFFF_FFFF, 5'd31, 5'd6, 32'h8000_0000, 1'b1);
    send(SHIFT_SRA, 32'h7FFF_FFF0, 5'd31, 5'd7, 32'h0000_0000, 1'b1);
    send(SHIFT_SRA, 32'h8000_0000, 5'd31, 5'd8, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Backpressure: five fill the pipe, the sixth waits
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d = $urandom;
      send(SHIFT_ROL, d, 5'(i + 3), 5'(i), model(SHIFT_ROL, d, 5'(i + 3)), 1'b0);
    end
    bus.in_valid      = 1'b1;
    bus.data_operand  = 32'hA5A5_0F0F;
    bus.ctrl_shiftamt = 5'd7;
    bus.ctrl_shift_op = SHIFT_SRA;
    bus.in_tag        = 5'd5;
    exp_res           = 32'hFF4B_4A1E;
    exp_lat           = 1'b0;
    @(negedge clock);
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_valid", bus.out_valid, 1);
    check("full_out_tag", bus.out_tag, 0);
    r0 = bus.result;
    t0 = bus.out_tag;
    repeat (3) begin
      @(negedge clock);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_result", bus.result, r0);
      check("stall_out_tag", bus.out_tag, t0);
    end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(negedge clock);
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    drain();

    // Bubble collapse: gapped issue into a stalled pipe
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d = $urandom;
      @(negedge clock);
      check("bubble_in_ready", bus.in_ready, 1);
      @(posedge clock);
      #1;
      send(SHIFT_SRL, d, 5'(2 * i + 1), 5'(10 + i), model(SHIFT_SRL, d, 5'(2 * i + 1)), 1'b0);
      repeat (2) @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("bubble_full", bus.in_ready, 0);
    repeat (3) @(posedge clock);
    #1 bus.out_ready = 1'b1;
    drain();

    // Random traffic with random output backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      shift_op_t   o = shift_op_t'($urandom_range(0, 3));
      logic [31:0] d = $urandom;
      logic [4:0]  s = 5'($urandom_range(0, 31));
      send(o, d, s, 5'(i), model(o, d, s), 1'b0);
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset with three operations in flight
    send(SHIFT_SLL, 32'h1, 5'd1, 5'd20, 32'h2, 1'b1);
    send(SHIFT_SLL, 32'h1, 5'd2, 5'd21, 32'h4, 1'b1);
    send(SHIFT_SLL, 32'h1, 5'd3, 5'd22, 32'h8, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    check("arst_out_tag", bus.out_tag, 0);
    check("arst_in_ready", bus.in_ready, 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    send(SHIFT_SLL, 32'h1, 5'd31, 5'd9, 32'h8000_0000, 1'b1);
    drain();

    check("sb_final_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
